periph_bus_router: RTL and testbench

PERIPH_BUS_ROUTER -- requirements
Module: periph_bus_router

---
 rtl/periph_bus_router.sv | 145 ++++++++++++++
 tb/tb_periph_bus_router.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_router.sv
// Routes single LSU accesses to one of N_SLV slave channels by address-region ID.
// Handles unmapped regions, slave timeouts and saturating error counting.
module periph_bus_router #(
    parameter int                 N_SLV   = 4,
    parameter logic [N_SLV*8-1:0] SLV_IDS = {8'd7, 8'd3, 8'd1, 8'd0},
    parameter int                 TIMEOUT = 16
) (
    input  logic                 clk_i,
    input  logic                 resetn_i,
    input  logic                 m_req_i,
    input  logic                 m_we_i,
    input  logic [3:0]           m_be_i,
    input  logic [31:0]          m_addr_i,
    input  logic [31:0]          m_wd_i,
    output logic [31:0]          m_rd_o,
    output logic                 m_ready_o,
    output logic                 m_err_o,
    output logic [N_SLV-1:0]     s_req_o,
    output logic                 s_we_o,
    output logic [3:0]           s_be_o,
    output logic [31:0]          s_addr_o,
    output logic [31:0]          s_wd_o,
    input  logic [N_SLV*32-1:0]  s_rd_i,
    input  logic [N_SLV-1:0]     s_ready_i,
    output logic                 busy_o,
    output logic [7:0]           err_cnt_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic             r_we;
    logic [3:0]       r_be;
    logic [23:0]      r_addr;
    logic [31:0]      r_wd;
    logic [N_SLV-1:0] r_sel;
    logic             r_err;
    logic [31:0]      r_rd;
    logic [7:0]       r_cnt;
    logic [7:0]       r_err_cnt;

    logic [N_SLV-1:0] w_match;
    logic             w_slv_ready;
    logic [31:0]      w_slv_rd;
    logic             w_timeout;

    // Descending scan so the lowest matching index overwrites any higher one.
    always_comb begin
        w_match = '0;
        for (int k = N_SLV - 1; k >= 0; k--) begin
            if (SLV_IDS[8*k +: 8] == m_addr_i[31:24]) begin
                w_match    = '0;
                w_match[k] = 1'b1;
            end
        end
    end

    always_comb begin
        w_slv_rd = '0;
        for (int k = 0; k < N_SLV; k++) begin
            if (r_sel[k]) begin
                w_slv_rd = w_slv_rd | s_rd_i[32*k +: 32];
            end
        end
    end

    assign w_slv_ready = |(s_ready_i & r_sel);
    assign w_timeout   = (r_cnt == CNT_LIMIT);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state   <= ST_IDLE;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_addr    <= '0;
            r_wd      <= '0;
            r_sel     <= '0;
            r_err     <= 1'b0;
            r_rd      <= '0;
            r_cnt     <= '0;
            r_err_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (m_req_i) begin
                        r_we   <= m_we_i;
                        r_be   <= m_be_i;
                        r_addr <= m_addr_i[23:0];
                        r_wd   <= m_wd_i;
                        r_sel  <= w_match;
                        r_cnt  <= '0;
                        if (|w_match) begin
                            r_err   <= 1'b0;
                            r_state <= ST_ISSUE;
                        end else begin
                            r_err   <= 1'b1;
                            r_rd    <= '0;
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    // Ready takes priority over a coincident timeout.
                    if (w_slv_ready) begin
                        r_rd    <= r_we ? 32'd0 : w_slv_rd;
                        r_err   <= 1'b0;
                        r_state <= ST_RESP;
                    end else if (w_timeout) begin
                        r_rd    <= '0;
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    if (r_err && (r_err_cnt != 8'hFF)) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Decoded from registered state so the reset drops s_req_o asynchronously.
    assign s_req_o   = (r_state == ST_ISSUE) ? r_sel : '0;
    assign s_we_o    = r_we;
    assign s_be_o    = r_be;
    assign s_addr_o  = {8'd0, r_addr};
    assign s_wd_o    = r_wd;
    assign m_ready_o = (r_state == ST_RESP);
    assign m_err_o   = (r_state == ST_RESP) && r_err;
    assign m_rd_o    = r_rd;
    assign busy_o    = (r_state != ST_IDLE);
    assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_periph_bus_router.sv
// Scoreboard bench for periph_bus_router: the driver pushes expected responses
// and slave issues, and an independent monitor pops and compares them.
module tb_periph_bus_router;

    localparam int N_SLV   = 4;
    localparam int TIMEOUT = 16;

    logic                clk;
    logic                resetn;
    logic                m_req, m_we;
    logic [3:0]          m_be;
    logic [31:0]         m_addr, m_wd;
    logic [31:0]         m_rd;
    logic                m_ready, m_err;
    logic [N_SLV-1:0]    s_req;
    logic                s_we;
    logic [3:0]          s_be;
    logic [31:0]         s_addr, s_wd;
    logic [N_SLV*32-1:0] s_rd;
    logic [N_SLV-1:0]    s_ready;
    logic                busy;
    logic [7:0]          err_cnt;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rd;
        logic        chk_rd;
    } resp_t;

    typedef struct {
        int          cyc;
        logic [3:0]  req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
    } iss_t;

    resp_t rq[$];
    iss_t  iq[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    model_errs = 0;
    int    ids[4] = '{0, 1, 3, 7};

    periph_bus_router #(
        .N_SLV   (N_SLV),
        .SLV_IDS ({8'd7, 8'd3, 8'd1, 8'd0}),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i     (clk),
        .resetn_i  (resetn),
        .m_req_i   (m_req),
        .m_we_i    (m_we),
        .m_be_i    (m_be),
        .m_addr_i  (m_addr),
        .m_wd_i    (m_wd),
        .m_rd_o    (m_rd),
        .m_ready_o (m_ready),
        .m_err_o   (m_err),
        .s_req_o   (s_req),
        .s_we_o    (s_we),
        .s_be_o    (s_be),
        .s_addr_o  (s_addr),
        .s_wd_o    (s_wd),
        .s_rd_i    (s_rd),
        .s_ready_i (s_ready),
        .busy_o    (busy),
        .err_cnt_o (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Lowest slave index whose region ID matches, or -1 when unmapped.
    function automatic int model_decode(input logic [7:0] id);
        for (int k = 0; k < N_SLV; k++) begin
            if (ids[k] == int'(id)) return k;
        end
        return -1;
    endfunction

    task automatic drive_slaves(input int idx, input int j, input int dly,
                                input logic [31:0] rdata);
        for (int k = 0; k < N_SLV; k++) s_rd[32*k +: 32] = $urandom;
        s_ready = 4'($urandom);
        if (idx >= 0) begin
            s_rd[32*idx +: 32] = rdata;
            s_ready[idx] = (j == dly);
        end
    endtask

    // dly: cycles after the ISSUE cycle before the selected slave raises ready.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input int dly, input logic [31:0] rdata,
                       input bit hold);
        int    idx;
        int    lat;
        resp_t r;
        iss_t  s;
        @(negedge clk);
        m_req  = 1'b1;
        m_we   = we;
        m_be   = be;
        m_addr = addr;
        m_wd   = wd;
        idx    = model_decode(addr[31:24]);
        drive_slaves(idx, -1, dly, rdata);
        if (idx < 0) begin
            lat = 1;
            r = '{cyc: cyc + 1, err: 1'b1, rd: 32'd0, chk_rd: 1'b0};
        end else if (dly <= TIMEOUT - 1) begin
            lat = 2 + dly;
            r = '{cyc: cyc + lat, err: 1'b0, rd: (we ? 32'd0 : rdata), chk_rd: 1'b1};
        end else begin
            lat = TIMEOUT + 1;
            r = '{cyc: cyc + lat, err: 1'b1, rd: 32'd0, chk_rd: 1'b1};
        end
        rq.push_back(r);
        if (idx >= 0) begin
            s = '{cyc: cyc + 1, req: 4'(1 << idx), we: we, be: be,
                  addr: {8'd0, addr[23:0]}, wd: wd};
            iq.push_back(s);
        end
        // Master inputs are scrambled while busy; the router must ignore them.
        for (int j = 0; j < lat; j++) begin
            @(negedge clk);
            m_req  = hold ? 1'b1 : 1'($urandom);
            m_we   = 1'($urandom);
            m_be   = 4'($urandom);
            m_addr = $urandom;
            m_wd   = $urandom;
            drive_slaves(idx, j, dly, rdata);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            m_req   = 1'b0;
            s_ready = '0;
        end
    endtask

    // Starts a never-answered access to ID 7 and resets it after `stay` cycles in flight.
    task automatic reset_mid(input int stay);
        @(negedge clk);
        m_req   = 1'b1;
        m_we    = 1'b0;
        m_be    = 4'hF;
        m_addr  = 32'h0700_0040;
        m_wd    = 32'h0;
        s_ready = '0;
        iq.push_back('{cyc: cyc + 1, req: 4'b1000, we: 1'b0, be: 4'hF,
                       addr: 32'h0000_0040, wd: 32'h0});
        for (int i = 0; i < stay; i++) begin
            @(negedge clk);
            m_req = 1'b0;
        end
        #2;
        resetn = 1'b0;
        #1;
        chk("async_sreq_drop", 64'(s_req), 64'd0);
        chk("async_busy_drop", 64'(busy), 64'd0);
        chk("async_ready_low", 64'(m_ready), 64'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a slave issue or completion.
    initial forever begin
        resp_t r;
        iss_t  s;
        @(negedge clk);
        if (!resetn) begin
            rq.delete();
            iq.delete();
            model_errs = 0;
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_m_ready", 64'(m_ready), 64'd0);
            chk("rst_s_req", 64'(s_req), 64'd0);
            chk("rst_err_cnt", 64'(err_cnt), 64'd0);
            chk("rst_m_rd", 64'(m_rd), 64'd0);
        end else begin
            if (s_req != '0) begin
                if (iq.size() == 0) begin
                    chk("unexpected_s_req", 64'(s_req), 64'd0);
                end else begin
                    s = iq.pop_front();
                    chk("issue_cycle", 64'(cyc), 64'(s.cyc));
                    chk("issue_s_req", 64'(s_req), 64'(s.req));
                    chk("issue_we_be", 64'({s_we, s_be}), 64'({s.we, s.be}));
                    chk("issue_addr", 64'(s_addr), 64'(s.addr));
                    chk("issue_wd", 64'(s_wd), 64'(s.wd));
                end
            end
            if (m_ready) begin
                if (rq.size() == 0) begin
                    chk("unexpected_m_ready", 64'(m_ready), 64'd0);
                end else begin
                    r = rq.pop_front();
                    chk("resp_cycle", 64'(cyc), 64'(r.cyc));
                    chk("resp_err", 64'(m_err), 64'(r.err));
                    if (r.chk_rd) chk("resp_rd", 64'(m_rd), 64'(r.rd));
                    chk("resp_err_cnt", 64'(err_cnt), 64'(model_errs));
                    model_errs = (model_errs + int'(r.err) > 255) ? 255
                                 : model_errs + int'(r.err);
                end
            end
        end
    end

    initial begin
        logic [7:0] rid;
        int         dly;
        resetn  = 1'b0;
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_be    = '0;
        m_addr  = '0;
        m_wd    = '0;
        s_rd    = '0;
        s_ready = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        idle(2);

        // Mapped read answered in ISSUE, unmapped, timeout, ready on the limit cycle.
        txn(1'b0, 32'h0300_0010, 4'hF, 32'h0, 0, 32'hCAFE_0001, 1'b0);
        txn(1'b0, 32'h0500_0000, 4'hF, 32'h0, 0, 32'h0, 1'b0);
        idle(1);
        chk("err_cnt_after_unmapped", 64'(err_cnt), 64'd1);
        txn(1'b1, 32'h0700_0004, 4'h3, 32'h1234_5678, 1000, 32'hDEAD_BEEF, 1'b0);
        txn(1'b1, 32'h0700_0008, 4'hC, 32'h8765_4321, TIMEOUT - 1, 32'h0, 1'b0);
        txn(1'b0, 32'h0700_000C, 4'hF, 32'h0, TIMEOUT - 1, 32'h5A5A_A5A5, 1'b0);
        txn(1'b0, 32'h0100_0020, 4'hF, 32'h0, 3, 32'h0BAD_F00D, 1'b0);
        idle(2);

        // Back-to-back writes to ID 0 with m_req held high.
        txn(1'b1, 32'h0000_0100, 4'h1, 32'h1111_0001, 0, 32'h0, 1'b1);
        txn(1'b1, 32'h0000_0104, 4'h2, 32'h2222_0002, 0, 32'h0, 1'b1);
        txn(1'b1, 32'h0000_0108, 4'h4, 32'h3333_0003, 0, 32'h0, 1'b1);
        idle(2);

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 4))
                0: rid = 8'd0;
                1: rid = 8'd1;
                2: rid = 8'd3;
                3: rid = 8'd7;
                default: rid = 8'($urandom);
            endcase
            dly = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 4);
            txn(1'($urandom), {rid, 24'($urandom)}, 4'($urandom), $urandom, dly, $urandom,
                1'($urandom));
        end
        idle(5);
        chk("drain_resp_queue", 64'(rq.size()), 64'd0);
        chk("drain_issue_queue", 64'(iq.size()), 64'd0);

        reset_mid(1);
        idle(2);
        reset_mid(2);
        idle(2);
        chk("post_reset_busy", 64'(busy), 64'd0);
        chk("post_reset_err_cnt", 64'(err_cnt), 64'd0);

        for (int i = 0; i < 256; i++) begin
            txn(1'($urandom), {8'h05, 24'($urandom)}, 4'($urandom), $urandom, 0, 32'h0, 1'b0);
        end
        idle(3);
        chk("err_cnt_saturated", 64'(err_cnt), 64'((256 > 255) ? 255 : 256));
        chk("final_resp_queue", 64'(rq.size()), 64'd0);
        chk("final_issue_queue", 64'(iq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
